// File: rtl/lsu_pkg.sv
// Shared types and widths for the load/store unit.
// Imported by the interfaces, the stack pointer and the top level.
package lsu_pkg;

    localparam int OP_W   = 2;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [OP_W-1:0] {
        LOAD  = 2'b00,
        STORE = 2'b01,
        PUSH  = 2'b10,
        POP   = 2'b11
    } lsu_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Request/response handshake bundle and data memory port bundle.
// The master side is the requester (or the LSU, for the memory port).
interface lsu_if;
    import lsu_pkg::*;

    logic              req_valid;
    logic              req_ready;
    lsu_op_e           req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

interface lsu_mem_if;
    import lsu_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr, mem_wdata, mem_we, mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_we, mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_stack_ptr.sv
// Stack pointer register; SP points at the next free slot and grows down.
// Strobes are ignored when they would cross the full/empty bounds.
module lsu_stack_ptr
    import lsu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] STACK_TOP   = 8'hFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hC0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    output logic [ADDR_W-1:0] sp,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W-1:0] FULL_SP = STACK_LIMIT - 8'd1;

    logic [ADDR_W-1:0] sp_q;
    logic [ADDR_W-1:0] sp_d;

    assign full  = (sp_q == FULL_SP);
    assign empty = (sp_q == STACK_TOP);
    assign sp    = sp_q;

    always_comb begin
        sp_d = sp_q;
        if (push && !full) begin
            sp_d = sp_q - 8'd1;
        end else if (pop && !empty) begin
            sp_d = sp_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= STACK_TOP;
        end else begin
            sp_q <= sp_d;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time, IDLE -> ACCESS -> RESP.
// Memory strobes are decoded from registered state only.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] STACK_TOP   = 8'hFF,
    parameter logic [ADDR_W-1:0] STACK_LIMIT = 8'hC0
) (
    input  logic              clk,
    input  logic              reset,
    lsu_if.slave              req,
    lsu_mem_if.master         mem,
    output logic [ADDR_W-1:0] sp
);

    lsu_state_e        state_q, state_d;
    lsu_op_e           op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_err_q, rsp_err_d;

    logic              sp_push;
    logic              sp_pop;
    logic              sp_full;
    logic              sp_empty;
    logic [ADDR_W-1:0] sp_cur;

    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              mem_we_c;
    logic              mem_re_c;

    lsu_stack_ptr #(
        .STACK_TOP   (STACK_TOP),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_sp (
        .clk   (clk),
        .reset (reset),
        .push  (sp_push),
        .pop   (sp_pop),
        .sp    (sp_cur),
        .full  (sp_full),
        .empty (sp_empty)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        sp_push     = 1'b0;
        sp_pop      = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        mem_we_c    = 1'b0;
        mem_re_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    op_d       = req.req_op;
                    addr_d     = req.req_addr;
                    wdata_d    = req.req_wdata;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b0;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
                unique case (op_q)
                    LOAD: begin
                        mem_addr_c = addr_q;
                        mem_re_c   = 1'b1;
                        rsp_data_d = mem.mem_rdata;
                    end
                    STORE: begin
                        mem_addr_c  = addr_q;
                        mem_wdata_c = wdata_q;
                        mem_we_c    = 1'b1;
                    end
                    PUSH: begin
                        if (sp_full) begin
                            rsp_err_d = 1'b1;
                        end else begin
                            mem_addr_c  = sp_cur;
                            mem_wdata_c = wdata_q;
                            mem_we_c    = 1'b1;
                            sp_push     = 1'b1;
                        end
                    end
                    POP: begin
                        // Empty stack: flag underflow, never touch memory.
                        if (sp_empty) begin
                            rsp_err_d  = 1'b1;
                            rsp_data_d = '0;
                        end else begin
                            mem_addr_c = sp_cur + 8'd1;
                            mem_re_c   = 1'b1;
                            rsp_data_d = mem.mem_rdata;
                            sp_pop     = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            RESP: begin
                if (req.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= LOAD;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    assign req.req_ready = (state_q == IDLE);
    assign req.rsp_valid = (state_q == RESP);
    assign req.rsp_data  = rsp_data_q;
    assign req.rsp_err   = rsp_err_q;

    assign mem.mem_addr  = mem_addr_c;
    assign mem.mem_wdata = mem_wdata_c;
    assign mem.mem_we    = mem_we_c;
    assign mem.mem_re    = mem_re_c;

    assign sp = sp_cur;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256x8 memory on the mem port.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sp;

    lsu_if     rif();
    lsu_mem_if mif();

    load_store_unit dut (
        .clk   (clk),
        .reset (reset),
        .req   (rif),
        .mem   (mif),
        .sp    (sp)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    int we_cnt   = 0;
    int re_cnt   = 0;
    int both_cnt = 0;

    assign mif.mem_rdata = mif.mem_re ? mem[mif.mem_addr] : 'z;

    always @(posedge clk) begin
        if (mif.mem_we) mem[mif.mem_addr] <= mif.mem_wdata;
        if (mif.mem_we) we_cnt <= we_cnt + 1;
        if (mif.mem_re) re_cnt <= re_cnt + 1;
        if (mif.mem_we && mif.mem_re) both_cnt <= both_cnt + 1;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic       acc_we, acc_re, acc_rv, rv1;
    logic [7:0] acc_addr, acc_wd;

    task automatic do_req(input lsu_op_e op, input logic [7:0] a,
                          input logic [7:0] d, output logic [7:0] rd,
                          output logic er);
        int n;
        rif.req_op    = op;
        rif.req_addr  = a;
        rif.req_wdata = d;
        rif.req_valid = 1'b1;
        n = 0;
        while (!rif.req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) check("accept_timeout", n, 0);
        @(posedge clk); #1;
        rif.req_valid = 1'b0;
        acc_we   = mif.mem_we;
        acc_re   = mif.mem_re;
        acc_addr = mif.mem_addr;
        acc_wd   = mif.mem_wdata;
        acc_rv   = rif.rsp_valid;
        @(posedge clk); #1;
        rv1 = rif.rsp_valid;
        n = 0;
        while (!rif.rsp_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 20) check("rsp_timeout", n, 0);
        rd = rif.rsp_data;
        er = rif.rsp_err;
        rif.rsp_ready = 1'b1;
        @(posedge clk); #1;
        rif.rsp_ready = 1'b0;
    endtask

    logic [7:0] rd;
    logic       er;
    int         w0, r0;

    initial begin
        reset         = 1'b1;
        rif.req_valid = 1'b0;
        rif.req_op    = LOAD;
        rif.req_addr  = '0;
        rif.req_wdata = '0;
        rif.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", rif.req_ready, 1);
        check("rst_rsp_valid", rif.rsp_valid, 0);
        check("rst_rsp_data", rif.rsp_data, 0);
        check("rst_rsp_err", rif.rsp_err, 0);
        check("rst_sp", sp, 8'hFF);
        check("rst_we_re", {mif.mem_we, mif.mem_re}, 0);
        check("rst_addr", mif.mem_addr, 0);
        check("rst_wdata", mif.mem_wdata, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Underflow from the empty stack.
        r0 = re_cnt;
        do_req(POP, 8'h00, 8'h00, rd, er);
        check("pop_empty_err", er, 1);
        check("pop_empty_data", rd, 0);
        check("pop_empty_re", re_cnt - r0, 0);
        check("pop_empty_sp", sp, 8'hFF);

        // Store then load back.
        w0 = we_cnt;
        do_req(STORE, 8'h10, 8'hA5, rd, er);
        check("st_acc_we", acc_we, 1);
        check("st_acc_addr", acc_addr, 8'h10);
        check("st_acc_wd", acc_wd, 8'hA5);
        check("st_we_cycles", we_cnt - w0, 1);
        check("st_mem", mem[8'h10], 8'hA5);
        check("st_rsp", {er, rd}, 0);
        do_req(LOAD, 8'h10, 8'h00, rd, er);
        check("ld_acc_re", acc_re, 1);
        check("ld_acc_rv", acc_rv, 0);
        check("ld_rv_next", rv1, 1);
        check("ld_data", rd, 8'hA5);
        check("ld_err", er, 0);
        check("ld_sp", sp, 8'hFF);
        do_req(STORE, 8'h20, 8'h77, rd, er);

        // Push/pop ordering.
        do_req(PUSH, 8'h00, 8'h11, rd, er);
        check("push1_addr", acc_addr, 8'hFF);
        check("push1_sp", sp, 8'hFE);
        do_req(PUSH, 8'h00, 8'h22, rd, er);
        check("push2_sp", sp, 8'hFD);
        check("mem_ff", mem[8'hFF], 8'h11);
        check("mem_fe", mem[8'hFE], 8'h22);
        do_req(POP, 8'h00, 8'h00, rd, er);
        check("pop1_addr", acc_addr, 8'hFE);
        check("pop1_data", rd, 8'h22);
        check("pop1_sp", sp, 8'hFE);
        do_req(POP, 8'h00, 8'h00, rd, er);
        check("pop2_data", rd, 8'h11);
        check("pop2_err", er, 0);
        check("pop2_sp", sp, 8'hFF);

        // Fill the stack, then overflow.
        for (int k = 0; k < 64; k++) begin
            do_req(PUSH, 8'h00, 8'(k), rd, er);
        end
        check("fill_sp", sp, 8'hBF);
        check("fill_mem_c0", mem[8'hC0], 8'h3F);
        check("fill_mem_ff", mem[8'hFF], 8'h00);
        w0 = we_cnt;
        do_req(PUSH, 8'h00, 8'h99, rd, er);
        check("ovf_err", er, 1);
        check("ovf_data", rd, 0);
        check("ovf_we", we_cnt - w0, 0);
        check("ovf_sp", sp, 8'hBF);
        do_req(POP, 8'h00, 8'h00, rd, er);
        check("pop_after_ovf", {er, rd}, 9'h03F);
        check("pop_after_ovf_sp", sp, 8'hC0);

        // Back-pressure on the response.
        rif.req_op    = LOAD;
        rif.req_addr  = 8'h10;
        rif.req_valid = 1'b1;
        @(posedge clk); #1;
        rif.req_valid = 1'b0;
        @(posedge clk); #1;
        rif.req_op    = STORE;
        rif.req_addr  = 8'h30;
        rif.req_wdata = 8'hEE;
        rif.req_valid = 1'b1;
        w0 = we_cnt;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("hold_valid", rif.rsp_valid, 1);
            check("hold_data", rif.rsp_data, 8'hA5);
            check("hold_ready", rif.req_ready, 0);
        end
        rif.req_valid = 1'b0;
        rif.rsp_ready = 1'b1;
        @(posedge clk); #1;
        rif.rsp_ready = 1'b0;
        check("hold_done_valid", rif.rsp_valid, 0);
        check("hold_done_ready", rif.req_ready, 1);
        check("hold_no_store", we_cnt - w0, 0);

        // Reset in the middle of a store access.
        rif.req_op    = STORE;
        rif.req_addr  = 8'h20;
        rif.req_wdata = 8'h5A;
        rif.req_valid = 1'b1;
        @(posedge clk); #1;
        rif.req_valid = 1'b0;
        check("mid_we_before", mif.mem_we, 1);
        reset = 1'b1;
        #1;
        check("mid_we_after", mif.mem_we, 0);
        check("mid_ready", rif.req_ready, 1);
        check("mid_valid", rif.rsp_valid, 0);
        check("mid_sp", sp, 8'hFF);
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid_mem_kept", mem[8'h20], 8'h77);
        do_req(LOAD, 8'h20, 8'h00, rd, er);
        check("mid_reload", rd, 8'h77);

        check("we_re_excl", both_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
